// File: rtl/chip8_alu_sequencer.sv
// rtl/chip8_alu_sequencer.sv - CHIP-8 8XYN arithmetic sequencer driving register file and shared ALU
//
// Purpose: executes 8XYN register-arithmetic instructions (N = 0-7, E). Reads Vx/Vy from a
// synchronous-read register file, drives the shared ALU, writes the result to Vx and, for
// flag ops, the controller-derived flag to VF. VF is always written last so it wins for x=F.
//
// Ports:
//   clk, reset_n            clock, asynchronous active-low reset
//   start, op_n, x, y       request pulse and operands, sampled only in IDLE
//   busy, done, illegal     status; done is a one-cycle pulse, illegal valid with done
//   rf_raddr_a/b, rf_rdata_a/b   register-file read port (data one cycle after address)
//   rf_we, rf_waddr, rf_wdata    register-file write port
//   alu_sel, alu_in1, alu_in2, alu_out   shared combinational ALU

typedef enum logic [2:0] {
   ALU_f_OR,
   ALU_f_AND,
   ALU_f_XOR,
   ALU_f_ADD,
   ALU_f_MINUS,
   ALU_f_RSHIFT,
   ALU_f_LSHIFT
} ALU_f;

module chip8_alu_sequencer (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        start,
   input  logic [3:0]  op_n,
   input  logic [3:0]  x,
   input  logic [3:0]  y,
   output logic        busy,
   output logic        done,
   output logic        illegal,
   output logic [3:0]  rf_raddr_a,
   output logic [3:0]  rf_raddr_b,
   input  logic [7:0]  rf_rdata_a,
   input  logic [7:0]  rf_rdata_b,
   output logic        rf_we,
   output logic [3:0]  rf_waddr,
   output logic [7:0]  rf_wdata,
   output ALU_f        alu_sel,
   output logic [15:0] alu_in1,
   output logic [15:0] alu_in2,
   input  logic [15:0] alu_out
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_READ,
      S_EXEC,
      S_WB_VX,
      S_WB_VF,
      S_DONE
   } state_t;

   state_t     state;
   logic [3:0] op_q;
   logic [3:0] x_q;
   logic [3:0] y_q;
   logic       flag_q;
   logic       exec_flag;
   logic       start_legal;
   logic       op_has_flag;
   logic       unused_alu_bits;

   assign start_legal     = (op_n <= 4'h7) || (op_n == 4'hE);
   assign op_has_flag     = (op_q >= 4'h4) && (op_q <= 4'h7) || (op_q == 4'hE);
   assign unused_alu_bits = ^alu_out[14:9];

   // ALU drive is combinational because Vx/Vy only arrive during EXEC.
   always_comb begin
      alu_sel = ALU_f_OR;
      alu_in1 = 16'h0000;
      alu_in2 = 16'h0000;
      if (state == S_EXEC) begin
         case (op_q)
            4'h0: begin
               alu_in1 = {8'h00, rf_rdata_b};
            end
            4'h1: begin
               alu_in1 = {8'h00, rf_rdata_a};
               alu_in2 = {8'h00, rf_rdata_b};
            end
            4'h2: begin
               alu_sel = ALU_f_AND;
               alu_in1 = {8'h00, rf_rdata_a};
               alu_in2 = {8'h00, rf_rdata_b};
            end
            4'h3: begin
               alu_sel = ALU_f_XOR;
               alu_in1 = {8'h00, rf_rdata_a};
               alu_in2 = {8'h00, rf_rdata_b};
            end
            4'h4: begin
               alu_sel = ALU_f_ADD;
               alu_in1 = {8'h00, rf_rdata_a};
               alu_in2 = {8'h00, rf_rdata_b};
            end
            4'h5: begin
               alu_sel = ALU_f_MINUS;
               alu_in1 = {8'h00, rf_rdata_a};
               alu_in2 = {8'h00, rf_rdata_b};
            end
            4'h6: begin
               alu_sel = ALU_f_RSHIFT;
               alu_in1 = {8'h00, rf_rdata_a};
               alu_in2 = 16'h0001;
            end
            4'h7: begin
               alu_sel = ALU_f_MINUS;
               alu_in1 = {8'h00, rf_rdata_b};
               alu_in2 = {8'h00, rf_rdata_a};
            end
            4'hE: begin
               alu_sel = ALU_f_LSHIFT;
               alu_in1 = {8'h00, rf_rdata_a};
               alu_in2 = 16'h0001;
            end
            default: ;
         endcase
      end
   end

   // Flags are derived here rather than taken from the ALU; a set sign bit on the
   // zero-extended subtraction means a borrow occurred.
   always_comb begin
      exec_flag = 1'b0;
      case (op_q)
         4'h4:        exec_flag = alu_out[8];
         4'h5, 4'h7:  exec_flag = ~alu_out[15];
         4'h6:        exec_flag = rf_rdata_a[0];
         4'hE:        exec_flag = rf_rdata_a[7];
         default:     exec_flag = 1'b0;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state      <= S_IDLE;
         op_q       <= 4'h0;
         x_q        <= 4'h0;
         y_q        <= 4'h0;
         flag_q     <= 1'b0;
         busy       <= 1'b0;
         done       <= 1'b0;
         illegal    <= 1'b0;
         rf_raddr_a <= 4'h0;
         rf_raddr_b <= 4'h0;
         rf_we      <= 1'b0;
         rf_waddr   <= 4'h0;
         rf_wdata   <= 8'h00;
      end else begin
         // Pulsed outputs default low; each state raises what its successor needs.
         done       <= 1'b0;
         illegal    <= 1'b0;
         rf_we      <= 1'b0;
         rf_waddr   <= 4'h0;
         rf_wdata   <= 8'h00;
         rf_raddr_a <= 4'h0;
         rf_raddr_b <= 4'h0;
         case (state)
            S_IDLE: begin
               if (start) begin
                  op_q <= op_n;
                  x_q  <= x;
                  y_q  <= y;
                  busy <= 1'b1;
                  if (start_legal) begin
                     state      <= S_READ;
                     rf_raddr_a <= x;
                     rf_raddr_b <= y;
                  end else begin
                     state   <= S_DONE;
                     done    <= 1'b1;
                     illegal <= 1'b1;
                  end
               end
            end
            S_READ: begin
               state      <= S_EXEC;
               rf_raddr_a <= x_q;
               rf_raddr_b <= y_q;
            end
            S_EXEC: begin
               state    <= S_WB_VX;
               flag_q   <= exec_flag;
               rf_we    <= 1'b1;
               rf_waddr <= x_q;
               rf_wdata <= alu_out[7:0];
            end
            S_WB_VX: begin
               if (op_has_flag) begin
                  state    <= S_WB_VF;
                  rf_we    <= 1'b1;
                  rf_waddr <= 4'hF;
                  rf_wdata <= {7'b0000000, flag_q};
               end else begin
                  state <= S_DONE;
                  done  <= 1'b1;
               end
            end
            S_WB_VF: begin
               state <= S_DONE;
               done  <= 1'b1;
            end
            S_DONE: begin
               state <= S_IDLE;
               busy  <= 1'b0;
            end
            default: begin
               state <= S_IDLE;
               busy  <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_chip8_alu_sequencer.sv
// tb/tb_chip8_alu_sequencer.sv - self-checking bench for chip8_alu_sequencer

module tb_chip8_alu_sequencer;

   logic        clk;
   logic        reset_n;
   logic        start;
   logic [3:0]  op_n;
   logic [3:0]  x;
   logic [3:0]  y;
   logic        busy;
   logic        done;
   logic        illegal;
   logic [3:0]  rf_raddr_a;
   logic [3:0]  rf_raddr_b;
   logic [7:0]  rf_rdata_a;
   logic [7:0]  rf_rdata_b;
   logic        rf_we;
   logic [3:0]  rf_waddr;
   logic [7:0]  rf_wdata;
   logic [2:0]  alu_sel;
   logic [15:0] alu_in1;
   logic [15:0] alu_in2;
   logic [15:0] alu_out;

   localparam logic [2:0] F_OR = 3'd0, F_AND = 3'd1, F_XOR = 3'd2, F_ADD = 3'd3;
   localparam logic [2:0] F_MINUS = 3'd4, F_RSHIFT = 3'd5, F_LSHIFT = 3'd6;

   int n_tests = 0;
   int n_fail  = 0;
   int we_count = 0;
   logic [11:0] exp_q[$];

   logic [7:0] regs [16];
   logic       tb_we;
   logic [3:0] tb_waddr;
   logic [7:0] tb_wdata;

   chip8_alu_sequencer dut (
      .clk(clk), .reset_n(reset_n), .start(start), .op_n(op_n), .x(x), .y(y),
      .busy(busy), .done(done), .illegal(illegal),
      .rf_raddr_a(rf_raddr_a), .rf_raddr_b(rf_raddr_b),
      .rf_rdata_a(rf_rdata_a), .rf_rdata_b(rf_rdata_b),
      .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
      .alu_sel(alu_sel), .alu_in1(alu_in1), .alu_in2(alu_in2), .alu_out(alu_out)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Register file with synchronous read, plus a bench-side preload port.
   always @(posedge clk) begin
      if (rf_we)
         regs[rf_waddr] <= rf_wdata;
      else if (tb_we)
         regs[tb_waddr] <= tb_wdata;
      rf_rdata_a <= regs[rf_raddr_a];
      rf_rdata_b <= regs[rf_raddr_b];
   end

   always_comb begin
      case (alu_sel)
         F_OR:     alu_out = alu_in1 | alu_in2;
         F_AND:    alu_out = alu_in1 & alu_in2;
         F_XOR:    alu_out = alu_in1 ^ alu_in2;
         F_ADD:    alu_out = alu_in1 + alu_in2;
         F_MINUS:  alu_out = alu_in1 - alu_in2;
         F_RSHIFT: alu_out = alu_in1 >> alu_in2;
         F_LSHIFT: alu_out = alu_in1 << alu_in2;
         default:  alu_out = 16'h0000;
      endcase
   end

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   // Write monitor: every write must match the head of the scoreboard.
   always @(negedge clk) begin
      if (reset_n && rf_we) begin
         logic [11:0] e;
         we_count++;
         if (exp_q.size() == 0) begin
            check_val("unexpected_write", {20'h0, rf_waddr, rf_wdata}, 32'h0);
         end else begin
            e = exp_q.pop_front();
            check_val("wr_addr", {28'h0, rf_waddr}, {28'h0, e[11:8]});
            check_val("wr_data", {24'h0, rf_wdata}, {24'h0, e[7:0]});
         end
      end
   end

   task automatic set_reg(input logic [3:0] a, input logic [7:0] d);
      tb_we = 1'b1; tb_waddr = a; tb_wdata = d;
      @(negedge clk);
      tb_we = 1'b0;
   endtask

   // Starts at a falling edge; returns at the falling edge of the IDLE cycle after done.
   task automatic do_op(input logic [3:0] nn, input logic [3:0] xa, input logic [3:0] ya,
                        input bit poke);
      logic [7:0] va, vb, res;
      logic [8:0] sum;
      logic       f, legal, has_f;
      logic [2:0] esel;
      int lat, cyc, done_cyc, busy_cnt, we0, nw;
      va = regs[xa]; vb = regs[ya];
      legal = (nn <= 4'h7) || (nn == 4'hE);
      has_f = legal && (nn >= 4'h4);
      f = 1'b0; res = 8'h00; esel = F_OR;
      case (nn)
         4'h0: res = vb;
         4'h1: res = va | vb;
         4'h2: begin res = va & vb; esel = F_AND; end
         4'h3: begin res = va ^ vb; esel = F_XOR; end
         4'h4: begin sum = {1'b0, va} + {1'b0, vb}; res = sum[7:0]; f = sum[8]; esel = F_ADD; end
         4'h5: begin res = va - vb; f = (va >= vb); esel = F_MINUS; end
         4'h7: begin res = vb - va; f = (vb >= va); esel = F_MINUS; end
         4'h6: begin res = va >> 1; f = va[0]; esel = F_RSHIFT; end
         4'hE: begin res = va << 1; f = va[7]; esel = F_LSHIFT; end
         default: ;
      endcase
      nw = 0;
      if (legal) begin exp_q.push_back({xa, res}); nw++; end
      if (has_f) begin exp_q.push_back({4'hF, 7'b0, f}); nw++; end
      lat = !legal ? 1 : (has_f ? 5 : 4);
      we0 = we_count;
      start = 1'b1; op_n = nn; x = xa; y = ya;
      @(posedge clk);
      @(negedge clk);
      start = 1'b0;
      cyc = 1; done_cyc = 0; busy_cnt = 0;
      while (done_cyc == 0 && cyc < 20) begin
         start = poke && (cyc == 2);
         if (start) begin op_n = 4'h4; x = 4'hF; y = 4'hF; end
         if (busy) busy_cnt++;
         if (legal && cyc == 1) check_val("raddr_a_read", {28'h0, rf_raddr_a}, {28'h0, xa});
         if (legal && cyc == 2) begin
            check_val("raddr_b_exec", {28'h0, rf_raddr_b}, {28'h0, ya});
            check_val("alu_sel_exec", {29'h0, alu_sel}, {29'h0, esel});
         end
         if (done) done_cyc = cyc;
         else begin @(negedge clk); cyc++; end
      end
      start = 1'b0;
      check_val("done_cycle", done_cyc, lat);
      check_val("busy_cycles", busy_cnt, lat);
      check_val("illegal", {31'h0, illegal}, {31'h0, !legal});
      @(negedge clk);
      check_val("idle_busy", {31'h0, busy}, 32'h0);
      check_val("write_count", we_count - we0, nw);
      check_val("scoreboard_empty", exp_q.size(), 0);
   endtask

   initial begin
      reset_n = 1'b0; start = 1'b0; op_n = 4'h0; x = 4'h0; y = 4'h0;
      tb_we = 1'b0; tb_waddr = 4'h0; tb_wdata = 8'h00;
      repeat (3) @(negedge clk);
      check_val("rst_busy", {31'h0, busy}, 32'h0);
      check_val("rst_done", {31'h0, done}, 32'h0);
      check_val("rst_illegal", {31'h0, illegal}, 32'h0);
      check_val("rst_we", {31'h0, rf_we}, 32'h0);
      check_val("rst_waddr_wdata", {20'h0, rf_waddr, rf_wdata}, 32'h0);
      check_val("rst_raddr", {24'h0, rf_raddr_a, rf_raddr_b}, 32'h0);
      check_val("rst_alu_sel", {29'h0, alu_sel}, {29'h0, F_OR});
      check_val("rst_alu_in", {alu_in1, alu_in2}, 32'h0);
      reset_n = 1'b1;
      for (int i = 0; i < 16; i++) set_reg(i[3:0], 8'h00);

      // ADD with carry
      set_reg(4'h3, 8'hF0); set_reg(4'h4, 8'h20);
      do_op(4'h4, 4'h3, 4'h4, 1'b0);
      check_val("add_v3", {24'h0, regs[3]}, 32'h10);
      check_val("add_vf", {24'h0, regs[15]}, 32'h01);

      // SUB borrow, SUB equal, SUBN (back-to-back after preloads)
      set_reg(4'h1, 8'h05); set_reg(4'h2, 8'h07);
      do_op(4'h5, 4'h1, 4'h2, 1'b0);
      check_val("sub_v1", {24'h0, regs[1]}, 32'hFE);
      check_val("sub_vf", {24'h0, regs[15]}, 32'h00);
      set_reg(4'h1, 8'h42); set_reg(4'h2, 8'h42);
      do_op(4'h5, 4'h1, 4'h2, 1'b0);
      check_val("sub_eq_v1", {24'h0, regs[1]}, 32'h00);
      check_val("sub_eq_vf", {24'h0, regs[15]}, 32'h01);
      set_reg(4'h1, 8'h05); set_reg(4'h2, 8'h07);
      do_op(4'h7, 4'h1, 4'h2, 1'b0);
      check_val("subn_v1", {24'h0, regs[1]}, 32'h02);
      check_val("subn_vf", {24'h0, regs[15]}, 32'h01);

      // Flag overrides result when x=F; then right shift
      set_reg(4'hF, 8'h81);
      do_op(4'hE, 4'hF, 4'h0, 1'b0);
      check_val("shl_vf_final", {24'h0, regs[15]}, 32'h01);
      set_reg(4'h2, 8'h03);
      do_op(4'h6, 4'h2, 4'h0, 1'b0);
      check_val("shr_v2", {24'h0, regs[2]}, 32'h01);
      check_val("shr_vf", {24'h0, regs[15]}, 32'h01);

      // Wrap-around on ADD, chained directly after another op
      set_reg(4'h5, 8'hFF); set_reg(4'h6, 8'h01);
      do_op(4'h4, 4'h5, 4'h6, 1'b0);
      do_op(4'h0, 4'h7, 4'h5, 1'b0);
      check_val("wrap_v5", {24'h0, regs[5]}, 32'h00);
      check_val("mov_v7", {24'h0, regs[7]}, 32'h00);

      // Logic op with a stray start in cycle 2
      set_reg(4'h0, 8'h0F); set_reg(4'h1, 8'hF0); set_reg(4'hF, 8'h55);
      do_op(4'h1, 4'h0, 4'h1, 1'b1);
      check_val("or_v0", {24'h0, regs[0]}, 32'hFF);
      check_val("or_vf_kept", {24'h0, regs[15]}, 32'h55);
      set_reg(4'h8, 8'hC3); set_reg(4'h9, 8'h5A);
      do_op(4'h2, 4'h8, 4'h9, 1'b0);
      do_op(4'h3, 4'h9, 4'h8, 1'b0);
      check_val("and_v8", {24'h0, regs[8]}, 32'h42);
      check_val("xor_v9", {24'h0, regs[9]}, 32'h18);

      // Illegal ops
      do_op(4'h9, 4'h1, 4'h2, 1'b0);
      do_op(4'hF, 4'h1, 4'h2, 1'b0);

      // Reset during WB_VX
      set_reg(4'h0, 8'h0F);
      exp_q.push_back({4'h0, 8'hFF});
      start = 1'b1; op_n = 4'h1; x = 4'h0; y = 4'h1;
      @(posedge clk); @(negedge clk); start = 1'b0;
      @(negedge clk); @(negedge clk);
      check_val("mid_we_before", {31'h0, rf_we}, 32'h1);
      #2 reset_n = 1'b0;
      #1;
      check_val("mid_we_dropped", {31'h0, rf_we}, 32'h0);
      check_val("mid_busy", {31'h0, busy}, 32'h0);
      check_val("mid_waddr_wdata", {20'h0, rf_waddr, rf_wdata}, 32'h0);
      check_val("mid_alu_sel", {29'h0, alu_sel}, {29'h0, F_OR});
      exp_q.delete();
      @(negedge clk);
      reset_n = 1'b1;
      @(negedge clk);
      check_val("mid_v0_kept", {24'h0, regs[0]}, 32'h0F);
      do_op(4'h1, 4'h0, 4'h1, 1'b0);
      check_val("post_reset_v0", {24'h0, regs[0]}, 32'hFF);

      repeat (2) @(negedge clk);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/chip8_alu_sequencer.md
# chip8_alu_sequencer

Multi-cycle controller that executes CHIP-8 8XYN register-arithmetic instructions (N = 0–7, E) on behalf of the CPU. It reads Vx and Vy from the register file, drives the shared ALU with the correct function and operand order, then writes the result back to Vx and the flag to VF. It sits between the CPU decode stage, the V-register file (synchronous read) and the ALU, so that VF handling lives in one place.

## Interface

Parameters:
- none

Ports:
- clk  in  1  system clock
- reset_n  in  1  asynchronous, active-low reset
- start  in  1  request pulse; sampled only in IDLE
- op_n  in  4  low nibble N of the 8XYN opcode
- x  in  4  destination/first-source register index
- y  in  4  second-source register index
- busy  out  1  high from the cycle after an accepted start through the done cycle, inclusive
- done  out  1  one-cycle completion pulse
- illegal  out  1  valid with done; 1 = unsupported N
- rf_raddr_a  out  4  register-file read address A (Vx)
- rf_raddr_b  out  4  register-file read address B (Vy)
- rf_rdata_a  in  8  read data A, valid one cycle after its address
- rf_rdata_b  in  8  read data B, valid one cycle after its address
- rf_we  out  1  register-file write enable
- rf_waddr  out  4  write address
- rf_wdata  out  8  write data
- alu_sel  out  ALU_f  ALU function select (enum from enums.svh)
- alu_in1  out  16  ALU operand 1; 8-bit value zero-extended
- alu_in2  out  16  ALU operand 2
- alu_out  in  16  ALU result (combinational)

## Operation

- Latching: on an accepted start, op_n, x and y are latched. Inputs are ignored while busy.
- States and transitions:
  - IDLE → READ on start with legal N.
  - IDLE → DONE on start with illegal N (N = 8–D or F).
  - READ → EXEC → WB_VX.
  - WB_VX → WB_VF for flag ops (5, 6, 7, 4, E).
  - WB_VX → DONE for ops 0–3.
  - WB_VF → DONE.
  - DONE → IDLE.
- Read addresses: rf_raddr_a = latched x and rf_raddr_b = latched y, held in READ and EXEC. They are 0 in all other states.
- EXEC drives the ALU as follows and registers result = alu_out[7:0] and flag:
  - N=0: OR, in1=Vy, in2=0.
  - N=1: OR, in1=Vx, in2=Vy.
  - N=2: AND, in1=Vx, in2=Vy.
  - N=3: XOR, in1=Vx, in2=Vy.
  - N=4: ADD, in1=Vx, in2=Vy; flag = alu_out[8].
  - N=5: MINUS, in1=Vx, in2=Vy; flag = ~alu_out[15] (1 when Vx ≥ Vy).
  - N=7: MINUS, in1=Vy, in2=Vx; flag = ~alu_out[15].
  - N=6: RSHIFT, in1=Vx, in2=1; flag = Vx[0].
  - N=E: LSHIFT, in1=Vx, in2=1; flag = Vx[7].
- Flags: the ALU's own alu_carry is not used; the controller derives every flag itself. Ops 0–3 leave VF unchanged.
- Idle ALU drive: outside EXEC, alu_sel = ALU_f_OR and alu_in1 = alu_in2 = 0.
- WB_VX: rf_we=1, rf_waddr=x, rf_wdata=result.
- WB_VF: rf_we=1, rf_waddr=0xF, rf_wdata={7'b0, flag}. Because VF is written last, the flag always wins when x=F.
- DONE: done=1 and busy=1. For an illegal op, illegal=1 and no rf_we is issued.

## Timing

- Reset values: busy=0, done=0, illegal=0, rf_we=0, rf_waddr=0, rf_wdata=0, rf_raddr_a=0, rf_raddr_b=0, alu_sel=ALU_f_OR, alu_in1=0, alu_in2=0; state=IDLE.
- Latency, with start sampled high at edge 0:
  - READ in cycle 1, EXEC in cycle 2, WB_VX in cycle 3.
  - Flag ops: WB_VF in cycle 4, done in cycle 5.
  - Ops 0–3: done in cycle 4.
  - Illegal ops: done in cycle 1.
- Back-to-back: the earliest next accepted start is sampled in the IDLE cycle after done, so the start-to-start minimum is 6 cycles for flag ops.
- Each write is exactly one cycle. rf_we is never high in READ, EXEC, DONE or IDLE.
- Reset mid-operation: reset_n low immediately forces IDLE and reset values, and no write is issued. A write cycle in progress is aborted combinationally.
- Widths: all arithmetic is zero-extended to 16 bits and the result is truncated to [7:0]. Wrap-around (e.g. 0xFF+0x01 → 0x00) is required.

## Test plan

- ADD with carry: V3=0xF0, V4=0x20, start N=4 x=3 y=4 → V3=0x10, VF=0x01, done exactly at cycle 5, busy cycles 1–5.
- SUB borrow and equal: V1=0x05, V2=0x07, N=5 → V1=0xFE, VF=0x00. Then V1=V2=0x42, N=5 → V1=0x00, VF=0x01. Also N=7 with V1=0x05, V2=0x07 → V1=0x02, VF=0x01.
- Flag overrides result: VF=0x81, N=E, x=F → writes VF=0x02 then VF=0x01, final VF=0x01. N=6 with V2=0x03 → V2=0x01, VF=0x01.
- Logic op: V0=0x0F, V1=0xF0, VF=0x55, N=1 x=0 y=1 → V0=0xFF, VF remains 0x55, done at cycle 4, exactly one rf_we pulse. A start pulsed in cycle 2 is ignored.
- Illegal op: N=9 → done and illegal high in cycle 1, no rf_we, back in IDLE in cycle 2.
- Reset mid-op: assert reset_n=0 during WB_VX → rf_we drops immediately, Vx is unchanged, all outputs are at reset values, and a new start after release completes normally.
